vga_frame_monitor: RTL and testbench
====================================

Name: vga_frame_monitor

Overview:
- Synthesizable, parametrised VGA stream monitor. It taps hsync, vsync and RGB on the pixel strobe and measures line and frame timing.
- Flags sticky timing errors and produces a per-frame checksum of the active region.
- Sits beside the top-level VGA output and is used by the top-level bench for self-checking over many frames. Resolution, polarity and pixel width are generic, replacing fixed 800x525 / 12-bit assumptions.

Parameters:
- H_TOTAL, 800, pixel samples per line
- H_SYNC, 96, hsync width in samples
- H_BP, 48, samples from hsync start-of-pulse end to first active pixel (active x starts at H_SYNC+H_BP)
- H_ACTIVE, 640, active pixels per line
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync width in lines
- V_BP, 33, lines after vsync end before first active line
- V_ACTIVE, 480, active lines per frame
- RGB_W, 12, pixel data width (1..32)
- HS_POL, 0, asserted level of hsync
- VS_POL, 0, asserted level of vsync
- CW, 12, width of h/v counters (saturating)

Ports:
- sys_clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- pix_en, in, 1, pixel strobe; all sampling only on sys_clk edges with pix_en=1
- vga_hs, in, 1, hsync under test
- vga_vs, in, 1, vsync under test
- vga_rgb, in, RGB_W, pixel data under test
- clr_err, in, 1, clears err (sync, single cycle)
- locked, out, 1, 1 while FSM in RUN
- frame_done, out, 1, one-cycle pulse per completed frame
- frame_cnt, out, 16, completed frames since reset (wraps)
- h_meas, out, CW, last measured line length
- v_meas, out, CW, last measured frame length in lines
- act_pix, out, 32, active pixels counted in last frame
- checksum, out, 32, checksum of last frame
- err, out, 6, sticky error flags

Behaviour:
- Reset: all outputs 0, FSM=SEEK, all counters/edge registers 0. The edge-detect history register loads the deasserted level.
- "Asserted" means pin==POL. A leading edge is a sample asserted where the previous sample was not.
- SEEK:
  - Ignore all checks and hold accumulators at 0.
  - On a vs leading edge, go to RUN with v_cnt=0, h_cnt=0, csum=0, act=0, first_line=1.
- RUN:
  - h_cnt increments each sample, saturating at 2^CW-1.
  - On an hs leading edge: if first_line=0, set h_meas<=h_cnt+1 and set err[0] if h_cnt+1!=H_TOTAL. Then h_cnt<=0, first_line<=0, and v_cnt<=v_cnt+1 unless a vs leading edge occurs in the same sample.
  - hs width: count consecutive asserted samples. On the deassert edge, set err[1] if count!=H_SYNC (not checked while first_line=1).
  - vs width: count hs leading edges while vs is asserted, including the edge coincident with the vs leading edge. On the vs deassert, set err[3] if count!=V_SYNC.
  - Active pixel: x=h_cnt-(H_SYNC+H_BP) in [0,H_ACTIVE) and y=v_cnt-(V_SYNC+V_BP) in [0,V_ACTIVE). On an active pixel, act<=act+1 and csum<={csum[30:0],csum[31]} ^ zero-extended vga_rgb.
- Frame end, on a vs leading edge in RUN:
  - Next cycle: frame_done=1; v_meas<=v_cnt+1; act_pix<=act; checksum<=csum; frame_cnt+1.
  - Set err[2] if v_cnt+1!=V_TOTAL and err[4] if act!=H_ACTIVE*V_ACTIVE.
  - Clear the accumulators and v_cnt in the same sample. The current pixel, if active, is not possible at that position.
- Timeout: in RUN, if h_cnt reaches 2*H_TOTAL samples with no hs edge, set err[5], go to SEEK and clear locked. No frame_done is issued for the partial frame.
- err bits are sticky. clr_err zeroes them in the next cycle. A new error set in the same cycle as clr_err wins (stays 1).
- pix_en=0: all state holds.
- rst mid-frame: immediate return to reset state. The first frame_done comes one full frame after the next vs leading edge.
- Latency: frame_done and the frame-level errors appear 1 sys_clk after the sampling edge of the vs leading edge. Line errors appear 1 cycle after their edge.

Test Plan:
- Defaults, pix_en every 4th cycle, conformant 640x480 timing, rgb=12'hFFF → frame_done at each vs edge after the first; h_meas=800, v_meas=525, act_pix=307200, err=0, frame_cnt=1,2,3.
- Small config (H_TOTAL=10, H_SYNC=2, H_BP=2, H_ACTIVE=4, V_TOTAL=6, V_SYNC=1, V_BP=1, V_ACTIVE=3), rgb=1 → act_pix=12, checksum=32'h00000FFF, err=0.
- Defaults, one line stretched to 801 samples → err[0]=1 and stays set; clr_err pulse → err=0 next cycle; later conformant frames keep err=0.
- hsync pulse of 95 samples on one line → err[1]=1 only. With VS_POL=1 and an inverted stream, 3-line vsync → err[3]=1.
- hs held deasserted for 1600 samples mid-frame → err[5]=1, locked=0, no frame_done until one full frame after the next vs leading edge.
- rst asserted mid-frame for 1 cycle → all outputs 0 next cycle; frame_cnt resumes at 1 one full frame after the next vs edge.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// VGA stream monitor: taps hsync/vsync/RGB on the pixel strobe, measures
// line and frame timing, flags sticky timing errors, checksums active video.
//
// Ports:
//   sys_clk    - system clock
//   rst        - synchronous active-high reset
//   pix_en     - pixel strobe; all sampling only on edges with pix_en=1
//   vga_hs     - hsync under test
//   vga_vs     - vsync under test
//   vga_rgb    - pixel data under test (RGB_W bits)
//   clr_err    - single-cycle clear of the sticky error flags
//   locked     - high while the monitor tracks frames (RUN)
//   frame_done - one-cycle pulse per completed frame
//   frame_cnt  - completed frames since reset (wraps)
//   h_meas     - last measured line length in samples
//   v_meas     - last measured frame length in lines
//   act_pix    - active pixels counted in the last frame
//   checksum   - rotate/xor checksum of the last frame's active pixels
//   err        - sticky errors:
//                [0] line length  [1] hsync width  [2] frame length
//                [3] vsync width  [4] active count [5] hsync timeout

module vga_frame_monitor #(
  parameter int   H_TOTAL  = 800,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   V_TOTAL  = 525,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACTIVE = 480,
  parameter int   RGB_W    = 12,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 12
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic [RGB_W-1:0] vga_rgb,
  input  logic             clr_err,
  output logic             locked,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [CW-1:0]    h_meas,
  output logic [CW-1:0]    v_meas,
  output logic [31:0]      act_pix,
  output logic [31:0]      checksum,
  output logic [5:0]       err
);

  localparam logic [31:0] L_HTOT = 32'(H_TOTAL);
  localparam logic [31:0] L_HSW  = 32'(H_SYNC);
  localparam logic [31:0] L_VTOT = 32'(V_TOTAL);
  localparam logic [31:0] L_VSW  = 32'(V_SYNC);
  localparam logic [31:0] L_X0   = 32'(H_SYNC + H_BP);
  localparam logic [31:0] L_Y0   = 32'(V_SYNC + V_BP);
  localparam logic [31:0] L_HACT = 32'(H_ACTIVE);
  localparam logic [31:0] L_VACT = 32'(V_ACTIVE);
  localparam logic [31:0] L_ACT  = 32'(H_ACTIVE * V_ACTIVE);
  localparam logic [31:0] L_TMO  = 32'(2 * H_TOTAL);

  typedef enum logic {
    S_SEEK = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // history holds "asserted" flags, so reset (0) is the deasserted level
  logic          r_hs_a;
  logic          r_vs_a;
  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [CW-1:0] r_hw;
  logic [CW-1:0] r_vw;
  logic          r_first;
  logic [31:0]   r_csum;
  logic [31:0]   r_act;

  logic          r_frame_done;
  logic [15:0]   r_frame_cnt;
  logic [CW-1:0] r_h_meas;
  logic [CW-1:0] r_v_meas;
  logic [31:0]   r_act_pix;
  logic [31:0]   r_checksum;
  logic [5:0]    r_err;

  logic        w_hs_a;
  logic        w_vs_a;
  logic        w_hs_le;
  logic        w_hs_fe;
  logic        w_vs_le;
  logic        w_vs_fe;
  logic        w_run;
  logic [31:0] w_h_inc;
  logic [31:0] w_v_inc;
  logic        w_tmo;
  logic        w_fend;
  logic        w_x_ok;
  logic        w_y_ok;
  logic        w_act;
  logic [5:0]  w_err_set;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (&v) ? v : v + CW'(1);
  endfunction

  assign w_hs_a  = (vga_hs == HS_POL);
  assign w_vs_a  = (vga_vs == VS_POL);
  assign w_hs_le = pix_en & w_hs_a & ~r_hs_a;
  assign w_hs_fe = pix_en & ~w_hs_a & r_hs_a;
  assign w_vs_le = pix_en & w_vs_a & ~r_vs_a;
  assign w_vs_fe = pix_en & ~w_vs_a & r_vs_a;
  assign w_run   = (r_state == S_RUN);

  assign w_h_inc = 32'(r_h_cnt) + 32'd1;
  assign w_v_inc = 32'(r_v_cnt) + 32'd1;

  // samples since the last hs edge reach twice a line: stream lost
  assign w_tmo  = w_run & pix_en & ~w_hs_le & (w_h_inc >= L_TMO);
  assign w_fend = w_run & w_vs_le & ~w_tmo;

  assign w_x_ok = (32'(r_h_cnt) >= L_X0) &&
                  (32'(r_h_cnt) <  L_X0 + L_HACT);
  assign w_y_ok = (32'(r_v_cnt) >= L_Y0) &&
                  (32'(r_v_cnt) <  L_Y0 + L_VACT);
  assign w_act  = w_run & pix_en & w_x_ok & w_y_ok & ~w_fend;

  always_comb begin
    w_err_set    = '0;
    w_err_set[0] = w_run & w_hs_le & ~r_first &
                   (w_h_inc != L_HTOT);
    w_err_set[1] = w_run & w_hs_fe & ~r_first &
                   (32'(r_hw) != L_HSW);
    w_err_set[2] = w_fend & (w_v_inc != L_VTOT);
    w_err_set[3] = w_run & w_vs_fe & (32'(r_vw) != L_VSW);
    w_err_set[4] = w_fend & (r_act != L_ACT);
    w_err_set[5] = w_tmo;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_SEEK: if (w_vs_le) w_state_nxt = S_RUN;
      S_RUN:  if (w_tmo)   w_state_nxt = S_SEEK;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= S_SEEK;
      r_hs_a       <= 1'b0;
      r_vs_a       <= 1'b0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_hw         <= '0;
      r_vw         <= '0;
      r_first      <= 1'b0;
      r_csum       <= '0;
      r_act        <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_h_meas     <= '0;
      r_v_meas     <= '0;
      r_act_pix    <= '0;
      r_checksum   <= '0;
      r_err        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_fend;
      // a flag raised in the clearing cycle survives the clear
      r_err <= (r_err & ~{6{clr_err}}) | w_err_set;

      if (pix_en) begin
        r_hs_a <= w_hs_a;
        r_vs_a <= w_vs_a;

        if (w_hs_a) begin
          r_hw <= w_hs_le ? CW'(1) : sat_inc(r_hw);
        end

        // the hs edge coincident with the vs edge counts as line one
        if (w_vs_le) begin
          r_vw <= w_hs_le ? CW'(1) : '0;
        end else if (w_vs_a && w_hs_le) begin
          r_vw <= sat_inc(r_vw);
        end

        if (!w_run || w_tmo) begin
          r_h_cnt <= '0;
          r_v_cnt <= '0;
          r_csum  <= '0;
          r_act   <= '0;
          r_first <= 1'b1;
        end else begin
          r_h_cnt <= sat_inc(r_h_cnt);

          if (w_act) begin
            r_act  <= r_act + 32'd1;
            r_csum <= {r_csum[30:0], r_csum[31]} ^
                      32'(vga_rgb);
          end

          if (w_hs_le) begin
            r_h_cnt <= '0;
            r_first <= 1'b0;
            if (!r_first) r_h_meas <= r_h_cnt + CW'(1);
            if (!w_vs_le) r_v_cnt <= sat_inc(r_v_cnt);
          end

          if (w_fend) begin
            r_v_meas    <= r_v_cnt + CW'(1);
            r_act_pix   <= r_act;
            r_checksum  <= r_csum;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_act       <= '0;
            r_csum      <= '0;
            r_v_cnt     <= '0;
          end
        end
      end
    end
  end

  assign locked     = (r_state == S_RUN);
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign h_meas     = r_h_meas;
  assign v_meas     = r_v_meas;
  assign act_pix    = r_act_pix;
  assign checksum   = r_checksum;
  assign err        = r_err;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor: default, small and inverted-polarity
// instances driven with hand-built line/frame streams.

module tb_vga_frame_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  pe;
  logic [2:0]  hs;
  logic [2:0]  vs;
  logic [2:0]  clr;
  logic [11:0] rgb;

  logic        a_lk, a_fd, b_lk, b_fd, c_lk, c_fd;
  logic [15:0] a_fc, b_fc, c_fc;
  logic [11:0] a_hm, a_vm, b_hm, b_vm, c_hm, c_vm;
  logic [31:0] a_ap, a_cs, b_ap, b_cs, c_ap, c_cs;
  logic [5:0]  a_er, b_er, c_er;

  int n_chk  = 0;
  int n_fail = 0;
  int n_fd_b = 0;
  int n_fd_c = 0;
  int k0;

  vga_frame_monitor u_a (
    .sys_clk(clk), .rst(rst[0]), .pix_en(pe[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_rgb(rgb),
    .clr_err(clr[0]), .locked(a_lk), .frame_done(a_fd),
    .frame_cnt(a_fc), .h_meas(a_hm), .v_meas(a_vm),
    .act_pix(a_ap), .checksum(a_cs), .err(a_er)
  );

  vga_frame_monitor #(
    .H_TOTAL(10), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4),
    .V_TOTAL(6), .V_SYNC(1), .V_BP(1), .V_ACTIVE(3)
  ) u_b (
    .sys_clk(clk), .rst(rst[1]), .pix_en(pe[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_rgb(rgb),
    .clr_err(clr[1]), .locked(b_lk), .frame_done(b_fd),
    .frame_cnt(b_fc), .h_meas(b_hm), .v_meas(b_vm),
    .act_pix(b_ap), .checksum(b_cs), .err(b_er)
  );

  vga_frame_monitor #(
    .H_TOTAL(10), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4),
    .V_TOTAL(6), .V_SYNC(2), .V_BP(1), .V_ACTIVE(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_c (
    .sys_clk(clk), .rst(rst[2]), .pix_en(pe[2]),
    .vga_hs(hs[2]), .vga_vs(vs[2]), .vga_rgb(rgb),
    .clr_err(clr[2]), .locked(c_lk), .frame_done(c_fd),
    .frame_cnt(c_fc), .h_meas(c_hm), .v_meas(c_vm),
    .act_pix(c_ap), .checksum(c_cs), .err(c_er)
  );

  always @(posedge clk) begin
    if (b_fd) n_fd_b++;
    if (c_fd) n_fd_c++;
  end

  // one pixel sample for instance k; ha/va are logical "asserted" levels
  task automatic smp(input int k, input bit ha, input bit va,
                     input logic [11:0] d, input bit c,
                     input int gap);
    pe[k]  = 1'b1;
    hs[k]  = (k == 2) ? ha : !ha;
    vs[k]  = (k == 2) ? va : !va;
    rgb    = d;
    clr[k] = c;
    @(negedge clk);
    pe[k]  = 1'b0;
    clr[k] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic line(input int k, input int htot, input int hsw,
                      input bit va, input logic [11:0] d,
                      input int cidx, input int gap);
    for (int i = 0; i < htot; i++)
      smp(k, i < hsw, va, d, i == cidx, gap);
  endtask

  // small-config frame: 6 lines of 10 samples, pix_en every 4th cycle
  task automatic frame(input int k, input int vsw,
                       input logic [11:0] d);
    for (int j = 0; j < 6; j++)
      line(k, 10, 2, j < vsw, d, -1, 3);
  endtask

  task automatic test_reset;
    rst = 3'b111;
    repeat (3) @(negedge clk);
    rst = 3'b000;
    @(negedge clk);
    n_chk++;
    if ({a_lk, a_fd, a_fc, a_hm, a_vm, a_ap, a_cs, a_er} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got %h want 0",
               {a_lk, a_fd, a_fc, a_hm, a_vm, a_ap, a_cs, a_er});
    end
    n_chk++;
    if ({b_lk, b_fd, b_fc, b_hm, b_vm, b_ap, b_cs, b_er} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got %h want 0",
               {b_lk, b_fd, b_fc, b_hm, b_vm, b_ap, b_cs, b_er});
    end
    n_chk++;
    if ({c_lk, c_fd, c_fc, c_hm, c_vm, c_ap, c_cs, c_er} !== '0) begin
      n_fail++;
      $display("FAIL reset_c: got %h want 0",
               {c_lk, c_fd, c_fc, c_hm, c_vm, c_ap, c_cs, c_er});
    end
  endtask

  task automatic test_line_len;
    line(0, 800, 96, 1, 12'h0, -1, 0);
    line(0, 800, 96, 1, 12'h0, -1, 0);
    line(0, 800, 96, 0, 12'h0, -1, 0);
    n_chk++;
    if (a_lk !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_a: locked=%b want 1", a_lk);
    end
    n_chk++;
    if (a_hm !== 12'd800 || a_er !== 6'd0) begin
      n_fail++;
      $display("FAIL line_ok: h_meas=%0d err=%b want 800 000000",
               a_hm, a_er);
    end
    line(0, 801, 96, 0, 12'h0, -1, 0);
    line(0, 800, 96, 0, 12'h0, -1, 0);
    n_chk++;
    if (a_hm !== 12'd801 || a_er !== 6'b000001) begin
      n_fail++;
      $display("FAIL line_801: h_meas=%0d err=%b want 801 000001",
               a_hm, a_er);
    end
    line(0, 800, 96, 0, 12'h0, -1, 0);
    n_chk++;
    if (a_hm !== 12'd800 || a_er !== 6'b000001) begin
      n_fail++;
      $display("FAIL err_sticky: h_meas=%0d err=%b want 800 000001",
               a_hm, a_er);
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    n_chk++;
    if (a_er !== 6'd0) begin
      n_fail++;
      $display("FAIL clr_err: err=%b want 000000", a_er);
    end
  endtask

  task automatic test_hsync_width;
    // clr_err lands on the very sample that raises err[1]
    line(0, 800, 95, 0, 12'h0, 95, 0);
    n_chk++;
    if (a_er !== 6'b000010) begin
      n_fail++;
      $display("FAIL hs_width: err=%b want 000010", a_er);
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    line(0, 800, 96, 0, 12'h0, -1, 0);
    n_chk++;
    if (a_er !== 6'd0 || a_hm !== 12'd800) begin
      n_fail++;
      $display("FAIL after_clr: err=%b h_meas=%0d want 000000 800",
               a_er, a_hm);
    end
  endtask

  task automatic test_timeout;
    line(0, 1700, 96, 0, 12'h0, -1, 0);
    n_chk++;
    if (a_er !== 6'b100000 || a_lk !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_a: err=%b locked=%b want 100000 0",
               a_er, a_lk);
    end
  endtask

  task automatic test_small_frames;
    for (int f = 1; f <= 4; f++) begin
      frame(1, 1, 12'h001);
      if (f >= 2) begin
        n_chk++;
        if (b_fc !== 16'(f - 1)) begin
          n_fail++;
          $display("FAIL frame_cnt_%0d: got %0d want %0d",
                   f, b_fc, f - 1);
        end
      end
    end
    n_chk++;
    if (b_ap !== 32'd12 || b_cs !== 32'h00000FFF) begin
      n_fail++;
      $display("FAIL small_sum: act=%0d cs=%h want 12 00000fff",
               b_ap, b_cs);
    end
    n_chk++;
    if (b_hm !== 12'd10 || b_vm !== 12'd6 || b_er !== 6'd0) begin
      n_fail++;
      $display("FAIL small_meas: h=%0d v=%0d err=%b want 10 6 0",
               b_hm, b_vm, b_er);
    end
    n_chk++;
    if (n_fd_b !== 3) begin
      n_fail++;
      $display("FAIL small_fd: pulses=%0d want 3", n_fd_b);
    end
  endtask

  task automatic test_checksum;
    frame(1, 1, 12'h800);
    frame(1, 1, 12'h800);
    n_chk++;
    if (b_cs !== 32'h007FF800 || b_fc !== 16'd5) begin
      n_fail++;
      $display("FAIL csum_800: cs=%h cnt=%0d want 007ff800 5",
               b_cs, b_fc);
    end
  endtask

  task automatic test_rst_midframe;
    line(1, 10, 2, 1, 12'h001, -1, 3);
    line(1, 10, 2, 0, 12'h001, -1, 3);
    line(1, 10, 2, 0, 12'h001, -1, 3);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    n_chk++;
    if ({b_lk, b_fd, b_fc, b_hm, b_vm, b_ap, b_cs, b_er} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got %h want 0",
               {b_lk, b_fd, b_fc, b_hm, b_vm, b_ap, b_cs, b_er});
    end
    frame(1, 1, 12'h001);
    n_chk++;
    if (b_fc !== 16'd0 || b_lk !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_relock: cnt=%0d locked=%b want 0 1",
               b_fc, b_lk);
    end
    frame(1, 1, 12'h001);
    n_chk++;
    if (b_fc !== 16'd1 || b_ap !== 32'd12) begin
      n_fail++;
      $display("FAIL rst_resume: cnt=%0d act=%0d want 1 12",
               b_fc, b_ap);
    end
  endtask

  task automatic test_timeout_recover;
    line(1, 25, 2, 0, 12'h001, -1, 3);
    n_chk++;
    if (b_er !== 6'b100000 || b_lk !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_b: err=%b locked=%b want 100000 0",
               b_er, b_lk);
    end
    k0 = n_fd_b;
    frame(1, 1, 12'h001);
    n_chk++;
    if (n_fd_b !== k0 || b_lk !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_nofd: pulses=%0d locked=%b want %0d 1",
               n_fd_b, b_lk, k0);
    end
    frame(1, 1, 12'h001);
    n_chk++;
    if (n_fd_b !== k0 + 1 || b_fc !== 16'd2) begin
      n_fail++;
      $display("FAIL tmo_fd: pulses=%0d cnt=%0d want %0d 2",
               n_fd_b, b_fc, k0 + 1);
    end
  endtask

  task automatic test_vsync_width;
    frame(2, 2, 12'h001);
    frame(2, 2, 12'h001);
    n_chk++;
    if (c_er !== 6'd0 || c_ap !== 32'd8 || c_cs !== 32'h000000FF) begin
      n_fail++;
      $display("FAIL inv_frame: err=%b act=%0d cs=%h want 0 8 ff",
               c_er, c_ap, c_cs);
    end
    n_chk++;
    if (c_vm !== 12'd6 || c_hm !== 12'd10) begin
      n_fail++;
      $display("FAIL inv_meas: v=%0d h=%0d want 6 10", c_vm, c_hm);
    end
    frame(2, 3, 12'h001);
    n_chk++;
    if (c_er !== 6'b001000 || n_fd_c !== 2) begin
      n_fail++;
      $display("FAIL vs_width: err=%b pulses=%0d want 001000 2",
               c_er, n_fd_c);
    end
  endtask

  initial begin
    pe  = 3'b000;
    clr = 3'b000;
    hs  = 3'b011;
    vs  = 3'b011;
    rgb = 12'h0;
    test_reset();
    test_line_len();
    test_hsync_width();
    test_timeout();
    test_small_frames();
    test_checksum();
    test_rst_midframe();
    test_timeout_recover();
    test_vsync_width();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
